// File: rtl/systolic_feeder.sv
// systolic_feeder
// Streams a 2x2 weight matrix and a sequence of activation rows into a 2x2 systolic array.
// Weights are shifted in over three cycles (column 1 first, column 2 one cycle behind).
// Activation rows are buffered in a 4-entry FIFO. Column 0 of each row goes to array row 1
// when the row is popped. Column 1 follows one cycle later on array row 2 (input skew).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   w_valid_in / w_ready_out      weight-set handshake; w_XY_in = W[X][Y], signed Q8.8
//   a_valid_in / a_ready_out      activation-row handshake; a_row_N_in = A[r][N]; a_last_in
//   sys_weight_in_x1/x2           weights to array columns 1/2
//   sys_accept_w_1/2              weight-shift enables for columns 1/2
//   sys_switch_in, sys_start      weight-switch strobe, row-1 activation valid
//   sys_data_in_1x/2x             activations to array rows 1/2
//   ub_rd_col_size_out/_valid_out column-size request to the unified buffer
//   busy_out, done_out            operation in progress, one-cycle completion pulse
module systolic_feeder (
   input  logic        clk,
   input  logic        rst,
   input  logic        w_valid_in,
   output logic        w_ready_out,
   input  logic [15:0] w_00_in,
   input  logic [15:0] w_01_in,
   input  logic [15:0] w_10_in,
   input  logic [15:0] w_11_in,
   input  logic        a_valid_in,
   output logic        a_ready_out,
   input  logic [15:0] a_row_0_in,
   input  logic [15:0] a_row_1_in,
   input  logic        a_last_in,
   output logic [15:0] sys_weight_in_x1,
   output logic [15:0] sys_weight_in_x2,
   output logic        sys_accept_w_1,
   output logic        sys_accept_w_2,
   output logic        sys_switch_in,
   output logic        sys_start,
   output logic [15:0] sys_data_in_1x,
   output logic [15:0] sys_data_in_2x,
   output logic [15:0] ub_rd_col_size_out,
   output logic        ub_rd_col_size_valid_out,
   output logic        busy_out,
   output logic        done_out
);

   localparam int unsigned Depth = 4;

   typedef enum logic [2:0] {StIdle, StLoadW0, StLoadW1, StFeed, StDrain} state_t;

   state_t      r_state;
   logic [15:0] r_w00, r_w01, r_w10, r_w11;
   logic        r_first_feed;  // high during the cycle right after LOAD_W1
   logic [15:0] r_skew;        // A[r][1] of the row popped last cycle, 0 if none

   logic [15:0] r_fifo_a0   [Depth];
   logic [15:0] r_fifo_a1   [Depth];
   logic        r_fifo_last [Depth];
   logic [1:0]  r_wr_ptr, r_rd_ptr;
   logic [2:0]  r_count;

   logic        w_empty, w_full, w_push, w_pop;
   logic [15:0] w_head_a0, w_head_a1;
   logic        w_head_last;

   assign w_empty     = (r_count == 3'd0);
   assign w_full      = (r_count == 3'd4);
   assign w_push      = a_valid_in && !w_full;
   assign w_pop       = ((r_state == StLoadW1) || (r_state == StFeed)) && !w_empty;
   assign w_head_a0   = r_fifo_a0[r_rd_ptr];
   assign w_head_a1   = r_fifo_a1[r_rd_ptr];
   assign w_head_last = r_fifo_last[r_rd_ptr];

   // FIFO storage needs no reset; the pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (!rst && w_push) begin
         r_fifo_a0[r_wr_ptr]   <= a_row_0_in;
         r_fifo_a1[r_wr_ptr]   <= a_row_1_in;
         r_fifo_last[r_wr_ptr] <= a_last_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= 2'd0;
         r_rd_ptr <= 2'd0;
         r_count  <= 3'd0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 3'd1;
            2'b01:   r_count <= r_count - 3'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= StIdle;
         r_w00        <= 16'd0;
         r_w01        <= 16'd0;
         r_w10        <= 16'd0;
         r_w11        <= 16'd0;
         r_first_feed <= 1'b0;
         r_skew       <= 16'd0;
      end else begin
         r_skew <= w_pop ? w_head_a1 : 16'd0;
         case (r_state)
            StIdle: begin
               if (w_valid_in) begin
                  r_w00   <= w_00_in;
                  r_w01   <= w_01_in;
                  r_w10   <= w_10_in;
                  r_w11   <= w_11_in;
                  r_state <= StLoadW0;
               end
            end
            StLoadW0: begin
               if (!w_empty) r_state <= StLoadW1;
            end
            StLoadW1: begin
               r_first_feed <= 1'b1;
               r_state      <= w_head_last ? StDrain : StFeed;
            end
            StFeed: begin
               r_first_feed <= 1'b0;
               if (w_pop && w_head_last) r_state <= StDrain;
            end
            StDrain: begin
               r_first_feed <= 1'b0;
               r_state      <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   always_comb begin
      w_ready_out              = (r_state == StIdle);
      a_ready_out              = !w_full;
      busy_out                 = (r_state != StIdle);
      done_out                 = 1'b0;
      sys_weight_in_x1         = 16'd0;
      sys_weight_in_x2         = 16'd0;
      sys_accept_w_1           = 1'b0;
      sys_accept_w_2           = 1'b0;
      sys_switch_in            = 1'b0;
      sys_start                = 1'b0;
      sys_data_in_1x           = 16'd0;
      sys_data_in_2x           = r_skew;
      ub_rd_col_size_out       = 16'd0;
      ub_rd_col_size_valid_out = 1'b0;
      unique case (r_state)
         StLoadW0: begin
            sys_accept_w_1           = 1'b1;
            sys_weight_in_x1         = r_w10;
            ub_rd_col_size_out       = 16'd2;
            ub_rd_col_size_valid_out = 1'b1;
         end
         StLoadW1: begin
            sys_accept_w_1   = 1'b1;
            sys_weight_in_x1 = r_w00;
            sys_accept_w_2   = 1'b1;
            sys_weight_in_x2 = r_w11;
            sys_switch_in    = 1'b1;
            sys_start        = w_pop;
            sys_data_in_1x   = w_pop ? w_head_a0 : 16'd0;
         end
         StFeed: begin
            // Column 2 lags column 1 by one cycle, so its last weight lands here.
            if (r_first_feed) begin
               sys_accept_w_2   = 1'b1;
               sys_weight_in_x2 = r_w01;
               sys_switch_in    = 1'b1;
            end
            sys_start      = w_pop;
            sys_data_in_1x = w_pop ? w_head_a0 : 16'd0;
         end
         StDrain: begin
            if (r_first_feed) begin
               sys_accept_w_2   = 1'b1;
               sys_weight_in_x2 = r_w01;
               sys_switch_in    = 1'b1;
            end
            done_out = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
